uart_apb_csr: RTL
=================

UART_APB_CSR -- requirements
Module: uart_apb_csr

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning UART character width; legal range 5..9.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning TX and RX FIFO depth; power of 2, range 2..128.
REQ-003 SHALL have parameter BAUD_RST, default 32'd0, meaning BAUD register reset value.
REQ-004 SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; everything is synchronous to its rising edge
- resetn  in  1  asynchronous, active-low reset
- PADDR  in  32  APB address
- PSELx  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  APB direction, 1 = write
- PWDATA  in  32  APB write data
- PSTRB  in  4  APB byte strobes
- PRDATA  out  32  APB read data
- PREADY  out  1  APB ready
- PSLVERR  out  1  APB error
- tx_data  out  DATA_W  TX FIFO head
- tx_valid  out  1  TX FIFO not empty
- tx_pop  in  1  core consumes tx_data
- rx_data  in  DATA_W  received character
- rx_push  in  1  core delivers rx_data
- parity_err, frame_err, break_err  in  1 each  single-cycle error pulses from core
- BAUD  out  32  baud divisor
- PARITY_MODE  out  2  parity mode
- STOP_BITS  out  2  stop-bit count
- TX_EN, RX_EN  out  1 each  core enables
- interrupt  out  1  registered interrupt

Function
REQ-005 SHALL complete every APB transfer in its access phase (PSELx&PENABLE) with PREADY=1; no wait states.
REQ-006 SHALL perform register side effects exactly once per transfer, in the access-phase cycle.
REQ-007 SHALL decode PADDR[7:0] as: 0x00 TXDATA (W), 0x04 RXDATA (R), 0x08 BAUD (RW), 0x0C STATUS (R), 0x10 CONTROL (RW), 0x14 STATUS_CLR (W1C), 0x18 INT_EN (RW).
REQ-008 SHALL assert PSLVERR with no side effect for unmapped addresses, writes to RXDATA/STATUS, reads of TXDATA/STATUS_CLR, TXDATA write with PSTRB[0]=0, TXDATA write when the TX FIFO is full and tx_pop=0, and RXDATA read when the RX FIFO is empty.
REQ-009 SHALL make PRDATA 0 for every read that asserts PSLVERR and for every non-read cycle.
REQ-010 SHALL write BAUD, CONTROL and INT_EN per byte lane gated by PSTRB.
REQ-011 SHALL place CONTROL fields at: [1:0] PARITY_MODE, [3:2] STOP_BITS, [4] TX_EN, [5] RX_EN; other bits read 0.
REQ-012 SHALL push PWDATA[DATA_W-1:0] into the TX FIFO on a TXDATA write; tx_data shows the head combinationally from FIFO storage; tx_pop with tx_valid=0 is ignored.
REQ-013 SHALL, on an RXDATA read, return the head in PRDATA[DATA_W-1:0] with upper bits 0, and pop it in the same cycle.
REQ-014 SHALL accept both operations when a push and a pop hit the same FIFO in one cycle, including a full FIFO (occupancy unchanged) and an empty FIFO (pop rejected, push accepted).
REQ-015 SHALL drop rx_push when the RX FIFO is full and no pop occurs that cycle, and set sticky OVERRUN.
REQ-016 SHALL implement wrap-around pointers of log2(FIFO_DEPTH) bits plus a count of log2(FIFO_DEPTH)+1 bits.
REQ-017 SHALL report STATUS as: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] PARITY, [5] FRAME, [6] OVERRUN, [7] BREAK, [15:8] tx_count, [23:16] rx_count, rest 0.
REQ-018 SHALL set STATUS[7:4] sticky on the matching error pulse and clear each bit on a STATUS_CLR write of 1 with PSTRB[0]=1; a set in the same cycle as a clear wins.
REQ-019 SHALL register interrupt = |(STATUS[7:0] & INT_EN[7:0]), with one cycle of latency.

Reset
REQ-020 SHALL, while resetn=0, force: FIFOs empty, pointers 0, STATUS sticky bits 0, CONTROL 0, INT_EN 0, BAUD=BAUD_RST, interrupt 0, PSLVERR 0, PRDATA 0, tx_valid 0.
REQ-021 SHALL abandon any in-flight APB transfer on reset mid-transfer, with no side effect.

Verification
REQ-022 Write BAUD=0x1 with PSTRB=0001, then read -> PRDATA=0x00000001; reset, then read -> PRDATA=BAUD_RST.
REQ-023 Write TXDATA 0xDEADBEEF with PSTRB=1111 -> tx_valid=1, tx_data=0xEF, STATUS[15:8]=1; write 0x1111DCBA with PSTRB=0000 -> PSLVERR=1, count unchanged.
REQ-024 Fill the TX FIFO with FIFO_DEPTH writes -> STATUS[0]=1; one more write -> PSLVERR=1; a write in the same cycle as tx_pop -> accepted, count stays FIFO_DEPTH.
REQ-025 FIFO_DEPTH+1 rx_push of 0x0A.. with no reads -> STATUS[6]=1, rx_count=FIFO_DEPTH; reads return data in order; read when empty -> PSLVERR=1, PRDATA=0.
REQ-026 INT_EN=0x20 with a frame_err pulse -> interrupt=1 one cycle later; STATUS_CLR 0x20 -> interrupt=0 next cycle; clear coinciding with a new frame_err -> bit stays 1.
REQ-027 Wrap test: 3*FIFO_DEPTH interleaved push/pop on both FIFOs -> data order preserved and counts exact at every step.

Source files
------------

// File: rtl/uart_apb_csr.sv
// UART control/status block: zero-wait-state APB slave with TX/RX character FIFOs,
// sticky line-error status and a registered interrupt.
module uart_apb_csr #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] BAUD_RST   = 32'd0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       PADDR,
    input  logic              PSELx,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PWDATA,
    input  logic [3:0]        PSTRB,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_pop,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_push,
    input  logic              parity_err,
    input  logic              frame_err,
    input  logic              break_err,
    output logic [31:0]       BAUD,
    output logic [1:0]        PARITY_MODE,
    output logic [1:0]        STOP_BITS,
    output logic              TX_EN,
    output logic              RX_EN,
    output logic              interrupt
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [7:0] A_TXDATA  = 8'h00;
    localparam logic [7:0] A_RXDATA  = 8'h04;
    localparam logic [7:0] A_BAUD    = 8'h08;
    localparam logic [7:0] A_STATUS  = 8'h0C;
    localparam logic [7:0] A_CONTROL = 8'h10;
    localparam logic [7:0] A_STCLR   = 8'h14;
    localparam logic [7:0] A_INTEN   = 8'h18;

    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]     tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic [CW-1:0]     tx_cnt, rx_cnt;
    logic [31:0]       baud_q;
    logic [5:0]        ctrl_q;
    logic [7:0]        int_en_q;
    logic [3:0]        sticky_q;
    logic              irq_q;

    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic        access;
    logic        tx_push, tx_pop_ok, rx_pop, rx_push_ok, overrun;
    logic        baud_we, ctrl_we, int_en_we;
    logic [3:0]  clr_bits, set_bits;
    logic        err;
    logic [31:0] rdata, status;
    logic        unused_addr;

    assign unused_addr = ^PADDR[31:8];

    assign tx_full  = (tx_cnt == CW'(FIFO_DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == CW'(FIFO_DEPTH));
    assign rx_empty = (rx_cnt == '0);

    // Sticky error order: {BREAK, OVERRUN, FRAME, PARITY}
    assign status = {8'h00, 8'(rx_cnt), 8'(tx_cnt), sticky_q,
                     rx_empty, rx_full, tx_empty, tx_full};

    // Reset gates the access phase so an interrupted transfer has no effect
    assign access = PSELx & PENABLE & resetn;

    // APB decode: error, read data and one-shot register side effects
    always_comb begin
        err       = 1'b0;
        rdata     = '0;
        tx_push   = 1'b0;
        rx_pop    = 1'b0;
        baud_we   = 1'b0;
        ctrl_we   = 1'b0;
        int_en_we = 1'b0;
        clr_bits  = '0;
        if (access) begin
            case (PADDR[7:0])
                A_TXDATA: begin
                    if (!PWRITE || !PSTRB[0] || (tx_full && !tx_pop)) err = 1'b1;
                    else                                               tx_push = 1'b1;
                end
                A_RXDATA: begin
                    if (PWRITE || rx_empty) err = 1'b1;
                    else begin
                        rx_pop = 1'b1;
                        rdata  = 32'(rx_mem[rx_rptr]);
                    end
                end
                A_BAUD: begin
                    if (PWRITE) baud_we = 1'b1;
                    else        rdata   = baud_q;
                end
                A_STATUS: begin
                    if (PWRITE) err   = 1'b1;
                    else        rdata = status;
                end
                A_CONTROL: begin
                    if (PWRITE) ctrl_we = 1'b1;
                    else        rdata   = 32'(ctrl_q);
                end
                A_STCLR: begin
                    if (!PWRITE)      err      = 1'b1;
                    else if (PSTRB[0]) clr_bits = PWDATA[7:4];
                end
                A_INTEN: begin
                    if (PWRITE) int_en_we = 1'b1;
                    else        rdata     = 32'(int_en_q);
                end
                default: err = 1'b1;
            endcase
        end
    end

    assign tx_pop_ok  = tx_pop & ~tx_empty;
    assign rx_push_ok = rx_push & (~rx_full | rx_pop);
    assign overrun    = rx_push & rx_full & ~rx_pop;
    assign set_bits   = {break_err, overrun, frame_err, parity_err};

    // FIFO storage is data-only and needs no reset
    always_ff @(posedge clk) begin
        if (tx_push)    tx_mem[tx_wptr] <= PWDATA[DATA_W-1:0];
        if (rx_push_ok) rx_mem[rx_wptr] <= rx_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_cnt   <= '0;
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_cnt   <= '0;
            baud_q   <= BAUD_RST;
            ctrl_q   <= '0;
            int_en_q <= '0;
            sticky_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (tx_push)    tx_wptr <= tx_wptr + AW'(1);
            if (tx_pop_ok)  tx_rptr <= tx_rptr + AW'(1);
            if (rx_push_ok) rx_wptr <= rx_wptr + AW'(1);
            if (rx_pop)     rx_rptr <= rx_rptr + AW'(1);
            case ({tx_push, tx_pop_ok})
                2'b10:   tx_cnt <= tx_cnt + CW'(1);
                2'b01:   tx_cnt <= tx_cnt - CW'(1);
                default: ;
            endcase
            case ({rx_push_ok, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + CW'(1);
                2'b01:   rx_cnt <= rx_cnt - CW'(1);
                default: ;
            endcase
            for (int i = 0; i < 4; i++) begin
                if (baud_we && PSTRB[i]) baud_q[8*i +: 8] <= PWDATA[8*i +: 8];
            end
            if (ctrl_we && PSTRB[0])   ctrl_q   <= PWDATA[5:0];
            if (int_en_we && PSTRB[0]) int_en_q <= PWDATA[7:0];
            sticky_q <= (sticky_q & ~clr_bits) | set_bits;
            irq_q    <= |(status[7:0] & int_en_q);
        end
    end

    assign PRDATA      = rdata;
    assign PSLVERR     = err;
    assign PREADY      = 1'b1;
    assign tx_data     = tx_mem[tx_rptr];
    assign tx_valid    = ~tx_empty;
    assign BAUD        = baud_q;
    assign PARITY_MODE = ctrl_q[1:0];
    assign STOP_BITS   = ctrl_q[3:2];
    assign TX_EN       = ctrl_q[4];
    assign RX_EN       = ctrl_q[5];
    assign interrupt   = irq_q;
endmodule
